demux_reg_16: RTL and testbench
===============================

Name: demux_reg_16

Overview:
Write-side counterpart of the 16:1 read multiplexer: a 1-to-16 demultiplexed register bank. A single N-bit write port plus 4-bit select steers data into one of 16 N-bit holding registers. All 16 registers are exposed in parallel so the datapath mux can read any of them. Adds a valid/ready write handshake, per-entry valid flags and a sequenced 16-cycle bulk clear, for use as the processor's general-purpose register file write path.

Parameters:
N, 8, data width of each register and of the write port

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
D  input  N  write data
S  input  4  write select, register index 0..15
WE  input  1  write request (valid)
WR_RDY  output  1  write accepted when WE && WR_RDY at rising clk
CLR  input  1  request bulk clear of all entries
BUSY  output  1  high while bulk clear in progress
O0..O15  output  N each  registered contents of entries 0..15
VLD  output  16  VLD[i]=1 when entry i written since last clear/reset

Behaviour:
- Async reset (rst_n=0): O0..O15=0, VLD=16'h0000, state=IDLE, clear counter=0, BUSY=0; WR_RDY=1 once rst_n=1 and CLR=0. Reset mid-clear aborts immediately to these values.
- States: IDLE, CLEAR. Encoding 1 bit.
- WR_RDY = (state==IDLE) && !CLR, combinational. BUSY = (state==CLEAR), registered state decode.
- IDLE, WE && WR_RDY: at edge, O[S] <= D, VLD[S] <= 1; other 15 entries and flags hold. Result visible on outputs the cycle after the edge (1-cycle latency). Back-to-back writes every cycle allowed; rewriting the same index overwrites, VLD stays 1.
- IDLE, WE=0: all entries hold.
- IDLE, CLR=1: WR_RDY forced low that cycle, any concurrent WE discarded (no entry modified); at edge state->CLEAR, counter=0.
- CLEAR: each cycle O[cnt] <= 0, VLD[cnt] <= 1'b0, cnt <= cnt+1. On the edge with cnt==15 (clearing entry 15) state->IDLE, cnt wraps to 0. Exactly 16 cycles in CLEAR; BUSY high for those 16 cycles.
- CLEAR: WE ignored (WR_RDY=0), CLR ignored (no restart). Entries not yet reached keep old values and flags until their cycle.
- Write index decoded to 16-bit one-hot enable; exactly one enable active per accepted write, none otherwise.
- No arithmetic other than 4-bit counter increment with natural wrap.
- S out of range impossible (4 bits covers 0..15); X on S while WE=0 has no effect.

Decomposition:
- Shared package: NUM_REGS=16, SEL_W=4, state constants ST_IDLE=1'b0, ST_CLEAR=1'b1.
- One sub-module: decoder_4to16 (inputs: 4-bit index, enable; output: 16-bit one-hot). Instantiated twice: write select (enable = WE && WR_RDY) and clear counter (enable = BUSY).
- Top holds the state register, counter and 16 N-bit registers.

Test Plan:
- Reset: drive rst_n=0 mid-run with data loaded -> all O=0, VLD=0, BUSY=0 immediately; after release WR_RDY=1.
- Single write: WE=1, S=4'd5, D=8'hA5 one cycle -> next cycle O5=8'hA5, VLD=16'h0020, all other O=0.
- Burst: write S=0..15 with D=8'h10+S on consecutive cycles -> after 16 cycles Oi=8'h10+i, VLD=16'hFFFF; rewrite S=3 with 8'h77 -> O3=8'h77, others unchanged.
- Clear: with all entries loaded, pulse CLR -> WR_RDY low same cycle; BUSY high exactly 16 cycles; after k cycles entries 0..k-1 are 0 with VLD low, entries k..15 unchanged; final VLD=0, WR_RDY=1.
- Collision: CLR=1 and WE=1, S=2, D=8'h55 same cycle -> O2 not written, clear sequence starts; WE pulses during BUSY change nothing.
- Reset mid-clear: assert rst_n=0 at clear cycle 7 -> immediate reset values, BUSY=0; after release, write S=9, D=8'h3C -> O9=8'h3C, VLD=16'h0200.

Source files
------------

// File: rtl/demux_reg_16_pkg.sv
// Shared constants for the demultiplexed 16-entry register bank.
package demux_reg_16_pkg;

  localparam int NUM_REGS = 16;
  localparam int SEL_W    = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/demux_reg_16_decoder.sv
// 4-to-16 one-hot decoder; all outputs low when not enabled.
module decoder_4to16
  import demux_reg_16_pkg::*;
(
  input  logic [SEL_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // idx is only looked at when enabled, so an X on idx cannot leak out.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_reg_16.sv
// 1-to-16 demultiplexed register bank with write handshake, per-entry valid
// flags and a sequenced one-entry-per-cycle bulk clear.
module demux_reg_16
  import demux_reg_16_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        D,
  input  logic [SEL_W-1:0]    S,
  input  logic                WE,
  output logic                WR_RDY,
  input  logic                CLR,
  output logic                BUSY,
  output logic [N-1:0]        O0,
  output logic [N-1:0]        O1,
  output logic [N-1:0]        O2,
  output logic [N-1:0]        O3,
  output logic [N-1:0]        O4,
  output logic [N-1:0]        O5,
  output logic [N-1:0]        O6,
  output logic [N-1:0]        O7,
  output logic [N-1:0]        O8,
  output logic [N-1:0]        O9,
  output logic [N-1:0]        O10,
  output logic [N-1:0]        O11,
  output logic [N-1:0]        O12,
  output logic [N-1:0]        O13,
  output logic [N-1:0]        O14,
  output logic [N-1:0]        O15,
  output logic [NUM_REGS-1:0] VLD
);

  logic [0:0]          state;
  logic [SEL_W-1:0]    cnt;
  logic [N-1:0]        regs [NUM_REGS];
  logic [NUM_REGS-1:0] vld;
  logic [NUM_REGS-1:0] wr_oh;
  logic [NUM_REGS-1:0] clr_oh;
  logic                wr_en;

  // A clear request wins over a concurrent write in the same cycle.
  assign WR_RDY = (state == ST_IDLE) && !CLR;
  assign BUSY   = (state == ST_CLEAR);
  assign wr_en  = WE && WR_RDY;

  decoder_4to16 u_wr_dec (
    .idx    (S),
    .en     (wr_en),
    .onehot (wr_oh)
  );

  decoder_4to16 u_clr_dec (
    .idx    (cnt),
    .en     (BUSY),
    .onehot (clr_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CLR) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (cnt == 4'd15) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Write and clear enables are mutually exclusive: one needs IDLE, the other CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_oh[i]) begin
          regs[i] <= D;
          vld[i]  <= 1'b1;
        end else if (clr_oh[i]) begin
          regs[i] <= '0;
          vld[i]  <= 1'b0;
        end
      end
    end
  end

  assign VLD = vld;
  assign O0  = regs[0];
  assign O1  = regs[1];
  assign O2  = regs[2];
  assign O3  = regs[3];
  assign O4  = regs[4];
  assign O5  = regs[5];
  assign O6  = regs[6];
  assign O7  = regs[7];
  assign O8  = regs[8];
  assign O9  = regs[9];
  assign O10 = regs[10];
  assign O11 = regs[11];
  assign O12 = regs[12];
  assign O13 = regs[13];
  assign O14 = regs[14];
  assign O15 = regs[15];

endmodule

// File: tb/tb_demux_reg_16.sv
// Directed self-checking bench for demux_reg_16.
module tb_demux_reg_16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  D;
  logic [3:0]  S;
  logic        WE;
  logic        CLR;
  logic        WR_RDY;
  logic        BUSY;
  logic [15:0] VLD;
  wire  [7:0]  o [16];

  int passed;
  int total;
  logic [7:0] exp_o [16];

  demux_reg_16 #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .S(S), .WE(WE), .WR_RDY(WR_RDY),
    .CLR(CLR), .BUSY(BUSY),
    .O0(o[0]), .O1(o[1]), .O2(o[2]), .O3(o[3]), .O4(o[4]), .O5(o[5]),
    .O6(o[6]), .O7(o[7]), .O8(o[8]), .O9(o[9]), .O10(o[10]), .O11(o[11]),
    .O12(o[12]), .O13(o[13]), .O14(o[14]), .O15(o[15]), .VLD(VLD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; D = '0; S = '0; WE = 1'b0; CLR = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (o[i] !== 8'h00) $display("FAIL reset_o[%0d]: got %h expected 00", i, o[i]);
      else passed++;
      exp_o[i] = 8'h00;
    end
    total++;
    if (VLD !== 16'h0000) $display("FAIL reset_vld: got %h expected 0000", VLD);
    else passed++;
    total++;
    if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", BUSY);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++;
    if (WR_RDY !== 1'b1) $display("FAIL reset_wr_rdy: got %b expected 1", WR_RDY);
    else passed++;
  endtask

  task automatic test_single_write();
    WE = 1'b1; S = 4'd5; D = 8'hA5;
    step();
    WE = 1'b0;
    exp_o[5] = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (o[i] !== exp_o[i]) $display("FAIL single_o[%0d]: got %h expected %h", i, o[i], exp_o[i]);
      else passed++;
    end
    total++;
    if (VLD !== 16'h0020) $display("FAIL single_vld: got %h expected 0020", VLD);
    else passed++;
  endtask

  task automatic test_burst();
    for (int s = 0; s < 16; s++) begin
      WE = 1'b1; S = 4'(s); D = 8'h10 + 8'(s);
      step();
    end
    WE = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_o[i] = 8'h10 + 8'(i);
      total++;
      if (o[i] !== exp_o[i]) $display("FAIL burst_o[%0d]: got %h expected %h", i, o[i], exp_o[i]);
      else passed++;
    end
    total++;
    if (VLD !== 16'hFFFF) $display("FAIL burst_vld: got %h expected FFFF", VLD);
    else passed++;
    WE = 1'b1; S = 4'd3; D = 8'h77;
    step();
    WE = 1'b0;
    exp_o[3] = 8'h77;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (o[i] !== exp_o[i]) $display("FAIL rewrite_o[%0d]: got %h expected %h", i, o[i], exp_o[i]);
      else passed++;
    end
    total++;
    if (VLD !== 16'hFFFF) $display("FAIL rewrite_vld: got %h expected FFFF", VLD);
    else passed++;
  endtask

  task automatic test_clear();
    CLR = 1'b1;
    #1;
    total++;
    if (WR_RDY !== 1'b0) $display("FAIL clr_wr_rdy: got %b expected 0", WR_RDY);
    else passed++;
    step();
    CLR = 1'b0;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (BUSY !== 1'b1) $display("FAIL clr_busy[%0d]: got %b expected 1", k, BUSY);
      else passed++;
      total++;
      if (WR_RDY !== 1'b0) $display("FAIL clr_rdy_busy[%0d]: got %b expected 0", k, WR_RDY);
      else passed++;
      total++;
      if (VLD !== (16'hFFFF << k)) $display("FAIL clr_vld[%0d]: got %h expected %h", k, VLD, 16'hFFFF << k);
      else passed++;
      for (int i = 0; i < 16; i++) begin
        total++;
        if (o[i] !== ((i < k) ? 8'h00 : exp_o[i]))
          $display("FAIL clr_o[%0d][%0d]: got %h expected %h", k, i, o[i], (i < k) ? 8'h00 : exp_o[i]);
        else passed++;
      end
      step();
    end
    for (int i = 0; i < 16; i++) exp_o[i] = 8'h00;
    total++;
    if (BUSY !== 1'b0) $display("FAIL clr_done_busy: got %b expected 0", BUSY);
    else passed++;
    total++;
    if (VLD !== 16'h0000) $display("FAIL clr_done_vld: got %h expected 0000", VLD);
    else passed++;
    total++;
    if (WR_RDY !== 1'b1) $display("FAIL clr_done_rdy: got %b expected 1", WR_RDY);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (o[i] !== 8'h00) $display("FAIL clr_done_o[%0d]: got %h expected 00", i, o[i]);
      else passed++;
    end
  endtask

  task automatic test_collision();
    WE = 1'b1; S = 4'd2; D = 8'h11;
    step();
    S = 4'd7; D = 8'h22;
    step();
    CLR = 1'b1; S = 4'd2; D = 8'h55;
    #1;
    total++;
    if (WR_RDY !== 1'b0) $display("FAIL coll_wr_rdy: got %b expected 0", WR_RDY);
    else passed++;
    step();
    CLR = 1'b0;
    total++;
    if (o[2] !== 8'h11) $display("FAIL coll_o2: got %h expected 11", o[2]);
    else passed++;
    total++;
    if (VLD !== 16'h0084) $display("FAIL coll_vld: got %h expected 0084", VLD);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (BUSY !== 1'b1) $display("FAIL coll_busy[%0d]: got %b expected 1", k, BUSY);
      else passed++;
      if (k == 5) begin
        total++;
        if (o[7] !== 8'h22) $display("FAIL coll_o7_kept: got %h expected 22", o[7]);
        else passed++;
        total++;
        if (o[2] !== 8'h00) $display("FAIL coll_o2_cleared: got %h expected 00", o[2]);
        else passed++;
        total++;
        if (VLD !== 16'h0080) $display("FAIL coll_vld_mid: got %h expected 0080", VLD);
        else passed++;
      end
      WE = 1'b1; S = 4'd7; D = 8'h99; CLR = (k == 8);
      step();
    end
    WE = 1'b0; CLR = 1'b0;
    total++;
    if (BUSY !== 1'b0) $display("FAIL coll_done_busy: got %b expected 0", BUSY);
    else passed++;
    total++;
    if (VLD !== 16'h0000) $display("FAIL coll_done_vld: got %h expected 0000", VLD);
    else passed++;
    total++;
    if (o[7] !== 8'h00) $display("FAIL coll_done_o7: got %h expected 00", o[7]);
    else passed++;
  endtask

  task automatic test_reset_mid_clear();
    WE = 1'b1; S = 4'd1; D = 8'hAA;
    step();
    S = 4'd14; D = 8'hBB;
    step();
    WE = 1'b0; CLR = 1'b1;
    step();
    CLR = 1'b0;
    repeat (7) step();
    total++;
    if (o[14] !== 8'hBB || BUSY !== 1'b1)
      $display("FAIL mid_pre: got o14=%h busy=%b expected o14=bb busy=1", o[14], BUSY);
    else passed++;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (o[i] !== 8'h00) $display("FAIL mid_rst_o[%0d]: got %h expected 00", i, o[i]);
      else passed++;
    end
    total++;
    if (VLD !== 16'h0000) $display("FAIL mid_rst_vld: got %h expected 0000", VLD);
    else passed++;
    total++;
    if (BUSY !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", BUSY);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (WR_RDY !== 1'b1 || BUSY !== 1'b0)
      $display("FAIL mid_release: got rdy=%b busy=%b expected rdy=1 busy=0", WR_RDY, BUSY);
    else passed++;
    WE = 1'b1; S = 4'd9; D = 8'h3C;
    step();
    WE = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (o[i] !== ((i == 9) ? 8'h3C : 8'h00))
        $display("FAIL mid_wr_o[%0d]: got %h expected %h", i, o[i], (i == 9) ? 8'h3C : 8'h00);
      else passed++;
    end
    total++;
    if (VLD !== 16'h0200) $display("FAIL mid_wr_vld: got %h expected 0200", VLD);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single_write();
    test_burst();
    test_clear();
    test_collision();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
